sram_controller: RTL

//  Bridges the MEM stage's 32-bit data-memory requests to the board's 16-bit asynchronous SRAM.

---
 rtl/sram_controller.sv | 109 ++++++++++
 1 files changed

// File: rtl/sram_controller.sv
// rtl/sram_controller.sv - 32-bit MEM-stage data port onto a 16-bit asynchronous SRAM
// Each access runs as two bus phases, low half then high half; ready freezes the pipeline meanwhile.
module sram_controller #(
  parameter int          WAIT_CYCLES   = 2,
  parameter logic [31:0] ADDR_OFFSET   = 32'd1024,
  parameter int          SRAM_ADDR_LEN = 18
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic                     rd_en,
  input  logic [31:0]              address,
  input  logic [31:0]              write_data,
  output logic [31:0]              read_data,
  output logic                     ready,
  inout  wire  [15:0]              SRAM_DQ,
  output logic [SRAM_ADDR_LEN-1:0] SRAM_ADDR,
  output logic                     SRAM_WE_N,
  output logic                     SRAM_UB_N,
  output logic                     SRAM_LB_N,
  output logic                     SRAM_CE_N,
  output logic                     SRAM_OE_N
);

  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  state_t                   state;
  logic [CW-1:0]            cnt;
  logic                     is_write;
  logic [31:0]              wdata_q;
  logic [SRAM_ADDR_LEN-2:0] word_q;
  logic                     dq_oe;
  logic [15:0]              dq_out;
  logic [31:0]              diff;
  logic [SRAM_ADDR_LEN-2:0] word_in;
  logic                     unused_bits;

  // Subtraction wraps, so addresses below the offset land at the top of the SRAM.
  assign diff        = address - ADDR_OFFSET;
  assign word_in     = diff[SRAM_ADDR_LEN:2];
  assign unused_bits = ^{diff[31:SRAM_ADDR_LEN+1], diff[1:0]};

  assign SRAM_DQ   = dq_oe ? dq_out : 16'hzzzz;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;

  assign ready = ((state == IDLE) && !wr_en && !rd_en) || (state == DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      is_write  <= 1'b0;
      wdata_q   <= '0;
      word_q    <= '0;
      dq_oe     <= 1'b0;
      dq_out    <= '0;
      read_data <= '0;
      SRAM_ADDR <= '0;
      SRAM_WE_N <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (wr_en || rd_en) begin
            state     <= LOW;
            cnt       <= '0;
            is_write  <= wr_en;
            wdata_q   <= write_data;
            word_q    <= word_in;
            SRAM_ADDR <= {word_in, 1'b0};
            SRAM_WE_N <= !wr_en;
            dq_oe     <= wr_en;
            dq_out    <= write_data[15:0];
          end
        end
        LOW: begin
          if (cnt == LAST) begin
            state     <= HIGH;
            cnt       <= '0;
            SRAM_ADDR <= {word_q, 1'b1};
            dq_out    <= wdata_q[31:16];
            if (!is_write) read_data[15:0] <= SRAM_DQ;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HIGH: begin
          if (cnt == LAST) begin
            state     <= DONE;
            cnt       <= '0;
            SRAM_WE_N <= 1'b1;
            dq_oe     <= 1'b0;
            if (!is_write) read_data[31:16] <= SRAM_DQ;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
